// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to a 16x16 register file,
// counts retired instructions and halts on HLT. Optional macro REGFILE_BYPASS_EN adds write-to-read bypass.
module wb_regfile #(
    parameter int         DATA_W  = 16,
    parameter int         NREGS   = 16,
    parameter int         ADDR_W  = 4,
    parameter logic [3:0] HALT_OP = 4'hF,
    parameter int         CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] WB_memdata,
    input  logic [DATA_W-1:0] WB_aluresult,
    input  logic [15:0]       WB_instr,
    input  logic              WB_RegWrite,
    input  logic              WB_memtoreg,
    input  logic              WB_inval,
    input  logic [ADDR_W-1:0] WB_regtowrite,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] wb_data,
    output logic              halt,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   regFile_q [NREGS];
    logic [CNT_W-1:0]    retireCnt_q, retireCnt_d;
    logic                valid;
    logic                isHalt;
    logic                commit;
    logic                unusedInstrBits;

    assign unusedInstrBits = ^WB_instr[11:0];

    assign wb_data = WB_memtoreg ? WB_memdata : WB_aluresult;
    assign valid   = ~WB_inval & (state_q != HALTED);
    assign isHalt  = (WB_instr[15:12] == HALT_OP);
    // HLT never writes, even if the decoder left RegWrite set.
    assign commit  = valid & WB_RegWrite & ~isHalt & (WB_regtowrite != '0);

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && valid && isHalt) begin
            state_d = HALTED;
        end
    end

    always_comb begin
        retireCnt_d = retireCnt_q;
        if (valid && retireCnt_q != '1) begin
            retireCnt_d = retireCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            retireCnt_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regFile_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            retireCnt_q <= retireCnt_d;
            if (commit) begin
                regFile_q[WB_regtowrite] <= wb_data;
            end
        end
    end

    always_comb begin
        rd_data1 = (rd_addr1 == '0) ? '0 : regFile_q[rd_addr1];
        rd_data2 = (rd_addr2 == '0) ? '0 : regFile_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        // commit already excludes R0, so a bypassed read can never leak into index 0.
        if (commit && rd_addr1 == WB_regtowrite) rd_data1 = wb_data;
        if (commit && rd_addr2 == WB_regtowrite) rd_data2 = wb_data;
`endif
    end

    assign halt       = (state_q == HALTED);
    assign retire_cnt = retireCnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile; a second instance with a 2-bit counter exercises saturation.
module tb_wb_regfile;

    typedef enum int {K_RD1, K_RD2, K_WB, K_HALT, K_CNT, K_SAT} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] expected;
        string       name;
    } check_t;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] memData = '0, aluResult = '0, instr = '0;
    logic        regWrite = 1'b0, memToReg = 1'b0, inval = 1'b1;
    logic [3:0]  dest = '0, rdAddr1 = '0, rdAddr2 = '0;
    logic [15:0] rdData1, rdData2, wbData, satRd1, satRd2, satWb;
    logic        halt, satHalt;
    logic [31:0] retireCnt;
    logic [1:0]  satCnt;

    check_t checkQueue[$];
    int     compared = 0;
    int     mismatched = 0;

    wb_regfile dut (
        .clk(clk), .rst(rst),
        .WB_memdata(memData), .WB_aluresult(aluResult), .WB_instr(instr),
        .WB_RegWrite(regWrite), .WB_memtoreg(memToReg), .WB_inval(inval),
        .WB_regtowrite(dest), .rd_addr1(rdAddr1), .rd_addr2(rdAddr2),
        .rd_data1(rdData1), .rd_data2(rdData2), .wb_data(wbData),
        .halt(halt), .retire_cnt(retireCnt)
    );

    wb_regfile #(.CNT_W(2)) dutSat (
        .clk(clk), .rst(rst),
        .WB_memdata(memData), .WB_aluresult(aluResult), .WB_instr(instr),
        .WB_RegWrite(regWrite), .WB_memtoreg(memToReg), .WB_inval(inval),
        .WB_regtowrite(dest), .rd_addr1(rdAddr1), .rd_addr2(rdAddr2),
        .rd_data1(satRd1), .rd_data2(satRd2), .wb_data(satWb),
        .halt(satHalt), .retire_cnt(satCnt)
    );

    always #5 clk = ~clk;

    // Monitor: drains every expectation queued during the current cycle at the falling edge.
    always @(negedge clk) begin
        while (checkQueue.size() > 0) begin
            check_t item;
            logic [31:0] actual;
            item = checkQueue.pop_front();
            case (item.kind)
                K_RD1:   actual = {16'h0, rdData1};
                K_RD2:   actual = {16'h0, rdData2};
                K_WB:    actual = {16'h0, wbData};
                K_HALT:  actual = {31'h0, halt};
                K_CNT:   actual = retireCnt;
                default: actual = {30'h0, satCnt};
            endcase
            compared++;
            if (actual !== item.expected) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h, expected %h", item.name, actual, item.expected);
            end
        end
    end

    task automatic checkOutput(input kind_t kind, input logic [31:0] expected, input string name);
        check_t item;
        item.kind = kind;
        item.expected = expected;
        item.name = name;
        checkQueue.push_back(item);
    endtask

    task automatic applyStimulus(input logic rw, input logic m2r, input logic inv,
                                 input logic [3:0] d, input logic [15:0] md,
                                 input logic [15:0] alu, input logic [15:0] ins,
                                 input logic [3:0] ra1, input logic [3:0] ra2);
        @(posedge clk);
        #1;
        regWrite = rw; memToReg = m2r; inval = inv; dest = d;
        memData = md; aluResult = alu; instr = ins;
        rdAddr1 = ra1; rdAddr2 = ra2;
    endtask

    task automatic bubble(input logic [3:0] ra1, input logic [3:0] ra2);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 16'h0, 16'h0, 16'h0, ra1, ra2);
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // Reset release, then sweep every index on both ports.
        for (int i = 0; i < 16; i++) begin
            bubble(4'(i), 4'(15 - i));
            if (i == 0) rst = 1'b1;
            checkOutput(K_RD1, 32'h0, $sformatf("reset rd1[%0d]", i));
            checkOutput(K_RD2, 32'h0, $sformatf("reset rd2[%0d]", 15 - i));
            checkOutput(K_HALT, 32'h0, "reset halt");
            checkOutput(K_CNT, 32'h0, "reset cnt");
        end

        // ALU write to R3.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 16'h0, 16'h1234, 16'h1000, 4'd3, 4'd0);
        checkOutput(K_WB, 32'h1234, "alu wb_data");
        checkOutput(K_RD1, BYPASS ? 32'h1234 : 32'h0, "alu same-cycle rd1");
        checkOutput(K_CNT, 32'd0, "alu cnt before");

        // Load write to R5, read R5 in the same cycle.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 16'hBEEF, 16'h9999, 16'h2000, 4'd3, 4'd5);
        checkOutput(K_RD1, 32'h1234, "R3 after alu write");
        checkOutput(K_CNT, 32'd1, "cnt after alu");
        checkOutput(K_WB, 32'hBEEF, "load wb_data");
        checkOutput(K_RD2, BYPASS ? 32'hBEEF : 32'h0, "load same-cycle rd2");

        // Write to R0.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 16'hFFFF, 16'h1000, 4'd5, 4'd0);
        checkOutput(K_RD1, 32'hBEEF, "R5 after load");
        checkOutput(K_CNT, 32'd2, "cnt after load");
        checkOutput(K_WB, 32'hFFFF, "r0 wb_data");
        checkOutput(K_RD2, 32'h0, "R0 during write");

        // Squashed write to R7.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd7, 16'h0, 16'h7777, 16'h1000, 4'd0, 4'd7);
        checkOutput(K_RD1, 32'h0, "R0 after write");
        checkOutput(K_RD2, 32'h0, "R7 during bubble write");
        checkOutput(K_CNT, 32'd3, "cnt after R0 write");

        bubble(4'd7, 4'd7);
        checkOutput(K_RD1, 32'h0, "R7 after bubble rd1");
        checkOutput(K_RD2, 32'h0, "R7 after bubble rd2");
        checkOutput(K_CNT, 32'd3, "cnt bubble not counted");

        // Valid instruction without RegWrite.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd4, 16'h0, 16'hAAAA, 16'h3000, 4'd4, 4'd4);
        checkOutput(K_CNT, 32'd3, "cnt before nowrite");
        checkOutput(K_RD1, 32'h0, "R4 nowrite same cycle");

        // HLT with RegWrite set must not write R6.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd6, 16'h0, 16'h6666, 16'hF000, 4'd6, 4'd4);
        checkOutput(K_CNT, 32'd4, "cnt nowrite counted");
        checkOutput(K_HALT, 32'h0, "halt not yet");
        checkOutput(K_RD1, 32'h0, "R6 during HLT");
        checkOutput(K_RD2, 32'h0, "R4 after nowrite");

        applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 16'h0, 16'h5555, 16'h1000, 4'd6, 4'd2);
        checkOutput(K_HALT, 32'h1, "halt set");
        checkOutput(K_CNT, 32'd5, "HLT counted");
        checkOutput(K_RD1, 32'h0, "R6 after HLT");
        checkOutput(K_RD2, 32'h0, "R2 halted write no bypass");

        bubble(4'd2, 4'd3);
        checkOutput(K_HALT, 32'h1, "halt sticky");
        checkOutput(K_CNT, 32'd5, "cnt frozen");
        checkOutput(K_RD1, 32'h0, "R2 write suppressed");
        checkOutput(K_RD2, 32'h1234, "reads work halted");

        // Reset pulsed between edges must clear immediately.
        bubble(4'd3, 4'd5);
        #2;
        rst = 1'b0;
        checkOutput(K_HALT, 32'h0, "async reset halt");
        checkOutput(K_CNT, 32'd0, "async reset cnt");
        checkOutput(K_RD1, 32'h0, "async reset R3");
        checkOutput(K_RD2, 32'h0, "async reset R5");

        bubble(4'd3, 4'd5);
        rst = 1'b1;
        checkOutput(K_HALT, 32'h0, "post reset halt");
        checkOutput(K_RD1, 32'h0, "post reset R3");

        // Saturation: 2-bit counter reaches 3 and stays.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 16'h1000, 4'd0, 4'd0);
            checkOutput(K_CNT, 32'(k - 1), $sformatf("run cnt %0d", k));
            checkOutput(K_SAT, (k - 1 > 3) ? 32'd3 : 32'(k - 1), $sformatf("sat cnt %0d", k));
        end
        bubble(4'd0, 4'd0);
        checkOutput(K_CNT, 32'd5, "run cnt final");
        checkOutput(K_SAT, 32'd3, "sat cnt final");

        repeat (2) @(posedge clk);
        if (checkQueue.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending checks, expected 0", checkQueue.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
